// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO/interrupt controller: register map, pin
// direction encoding and bus polarity.
package gpio_irq_pkg;

  localparam logic [3:0] GPIO_ADDR_IN_DATA  = 4'd0;
  localparam logic [3:0] GPIO_ADDR_OUT_DATA = 4'd1;
  localparam logic [3:0] GPIO_ADDR_IO_DATA  = 4'd2;
  localparam logic [3:0] GPIO_ADDR_IO_DIR   = 4'd3;
  localparam logic [3:0] GPIO_ADDR_OUT_SET  = 4'd4;
  localparam logic [3:0] GPIO_ADDR_OUT_CLR  = 4'd5;
  localparam logic [3:0] GPIO_ADDR_IRQ_RISE = 4'd6;
  localparam logic [3:0] GPIO_ADDR_IRQ_FALL = 4'd7;
  localparam logic [3:0] GPIO_ADDR_IRQ_STAT = 4'd8;

  localparam logic GPIO_DIR_IN  = 1'b0;
  localparam logic GPIO_DIR_OUT = 1'b1;

  localparam logic GPIO_READ  = 1'b1;
  localparam logic GPIO_WRITE = 1'b0;

  // cs_, as_ and rdy_ are all active-low strobes
  localparam logic GPIO_ASSERT_L = 1'b0;
  localparam logic GPIO_IDLE_L   = 1'b1;

endpackage

// File: rtl/gpio_irq_if.sv
// Chip-selected peripheral bus between the bus master and the GPIO slave.
interface gpio_irq_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/gpio_irq_sync_edge.sv
// Two-flop synchronizer with a history flop; rise/fall are single-cycle
// pulses derived from the synchronized value.
module gpio_sync_edge #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pin,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1_q, s2_q, prev_q;
  logic [W-1:0] s1_d, s2_d, prev_d;

  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;
endmodule

// File: rtl/gpio_irq.sv
// GPIO controller: register file on a single-cycle chip-selected bus,
// tristate pad drivers and latched per-pin edge interrupts.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int IN_CH  = 4,
  parameter int OUT_CH = 18,
  parameter int IO_CH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  gpio_irq_if.slave         bus,
  input  logic [IN_CH-1:0]  gpio_in,
  output logic [OUT_CH-1:0] gpio_out,
  inout  wire  [IO_CH-1:0]  gpio_io,
  output logic              irq
);
  localparam int IRQ_W = IN_CH + IO_CH;

  logic [IRQ_W-1:0]  sync, rise, fall;
  logic [IN_CH-1:0]  in_sync;
  logic [IO_CH-1:0]  io_sync;

  logic [OUT_CH-1:0] out_q, out_d;
  logic [IO_CH-1:0]  io_out_q, io_out_d, io_dir_q, io_dir_d;
  logic [IRQ_W-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [IRQ_W-1:0]  stat_q, stat_d, clr;
  logic              irq_q, irq_d, rdy_q, rdy_d;
  logic [31:0]       rd_data_q, rd_data_d, rd_mux;
  logic              access, wr_en, rd_en;
  logic              unused_wr_bits;

  gpio_sync_edge #(.W(IRQ_W)) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .pin   ({gpio_io, gpio_in}),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  assign in_sync = sync[IN_CH-1:0];
  assign io_sync = sync[IRQ_W-1:IN_CH];
  assign unused_wr_bits = ^bus.wr_data;

  always_comb begin
    access = (bus.cs_ == GPIO_ASSERT_L) && (bus.as_ == GPIO_ASSERT_L);
    wr_en  = access && (bus.rw == GPIO_WRITE);
    rd_en  = access && (bus.rw == GPIO_READ);

    case (bus.addr)
      GPIO_ADDR_IN_DATA:  rd_mux = 32'(in_sync);
      GPIO_ADDR_OUT_DATA: rd_mux = 32'(out_q);
      GPIO_ADDR_IO_DATA:  rd_mux = 32'(io_sync);
      GPIO_ADDR_IO_DIR:   rd_mux = 32'(io_dir_q);
      GPIO_ADDR_IRQ_RISE: rd_mux = 32'(rise_en_q);
      GPIO_ADDR_IRQ_FALL: rd_mux = 32'(fall_en_q);
      GPIO_ADDR_IRQ_STAT: rd_mux = 32'(stat_q);
      default:            rd_mux = '0;
    endcase

    out_d     = out_q;
    io_out_d  = io_out_q;
    io_dir_d  = io_dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (wr_en) begin
      case (bus.addr)
        GPIO_ADDR_OUT_DATA: out_d     = bus.wr_data[OUT_CH-1:0];
        GPIO_ADDR_OUT_SET:  out_d     = out_q | bus.wr_data[OUT_CH-1:0];
        GPIO_ADDR_OUT_CLR:  out_d     = out_q & ~bus.wr_data[OUT_CH-1:0];
        GPIO_ADDR_IO_DATA:  io_out_d  = bus.wr_data[IO_CH-1:0];
        GPIO_ADDR_IO_DIR:   io_dir_d  = bus.wr_data[IO_CH-1:0];
        GPIO_ADDR_IRQ_RISE: rise_en_d = bus.wr_data[IRQ_W-1:0];
        GPIO_ADDR_IRQ_FALL: fall_en_d = bus.wr_data[IRQ_W-1:0];
        GPIO_ADDR_IRQ_STAT: clr       = bus.wr_data[IRQ_W-1:0];
        default: ;
      endcase
    end

    // New events are OR-ed in after the clear, so a colliding edge wins
    stat_d    = (stat_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d     = |stat_d;
    rdy_d     = access ? GPIO_ASSERT_L : GPIO_IDLE_L;
    rd_data_d = rd_en ? rd_mux : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      io_out_q  <= '0;
      io_dir_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
      rdy_q     <= GPIO_IDLE_L;
      rd_data_q <= '0;
    end else begin
      out_q     <= out_d;
      io_out_q  <= io_out_d;
      io_dir_q  <= io_dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      irq_q     <= irq_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  for (genvar i = 0; i < IO_CH; i++) begin : g_pad
    assign gpio_io[i] = (io_dir_q[i] == GPIO_DIR_OUT) ? io_out_q[i] : 1'bz;
  end

  assign gpio_out    = out_q;
  assign irq         = irq_q;
  assign bus.rdy_    = rdy_q;
  assign bus.rd_data = rd_data_q;
endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised general-purpose I/O controller that generalises the base GPIO block. It provides configurable input, output and bidirectional channel counts, plus write-1 set/clear on outputs. Every input-capable pin gets a two-flop synchronizer, and per-pin rising/falling edge interrupts are latched in a write-1-to-clear status register. The block sits on the peripheral bus as a chip-selected slave and drives one level interrupt line to the interrupt controller.

## Interface

Parameters:
- IN_CH, 4, input-only channels (1..32)
- OUT_CH, 18, output-only channels (1..32)
- IO_CH, 16, bidirectional channels (1..32); IN_CH+IO_CH ≤ 32 (interrupt-capable width, IRQ_W)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cs_  in  1  chip select, active low
- as_  in  1  address strobe, active low
- rw  in  1  1=read, 0=write
- addr  in  4  word register address
- wr_data  in  32  write data
- rd_data  out  32  read data
- rdy_  out  1  access acknowledge, active low
- gpio_in  in  IN_CH  input pins (asynchronous)
- gpio_out  out  OUT_CH  output pins
- gpio_io  inout  IO_CH  bidirectional pins
- irq  out  1  level interrupt, active high

## Operation

- Access = cs_==0 && as_==0 sampled at a clk edge. Single-cycle slave, no wait states.
- Register map (addr), unused bits read 0:
  - 0 IN_DATA, ro: synchronized gpio_in.
  - 1 OUT_DATA, rw: gpio_out.
  - 2 IO_DATA: read returns synchronized gpio_io pins; write loads io_out.
  - 3 IO_DIR, rw: 1=output, 0=input (Hi-Z).
  - 4 OUT_SET, wo: gpio_out |= wr_data. Reads 0.
  - 5 OUT_CLR, wo: gpio_out &= ~wr_data. Reads 0.
  - 6 IRQ_RISE, rw: per-bit rising-edge enable.
  - 7 IRQ_FALL, rw: per-bit falling-edge enable.
  - 8 IRQ_STAT, rw1c: latched edge events.
  - 9–15: reads 0, writes ignored.
- Interrupt bit vector is {io_sync, in_sync}: bits [IN_CH-1:0] are gpio_in, the next IO_CH bits are gpio_io.
- gpio_io[i] = io_dir[i] ? io_out[i] : 1'bz. The input path samples the pad regardless of direction, so output pins read back their driven value.
- Sync/edge path per bit:
  - s1 <= pin, s2 <= s1, prev <= s2.
  - rise = s2 & ~prev; fall = ~s2 & prev.
- Status update: stat_next = (stat & ~clr) | (rise & IRQ_RISE) | (fall & IRQ_FALL), where clr = wr_data when writing addr 8, else 0.
- irq <= |stat_next. It is registered and changes in the same cycle as stat.
- A bit with both enables set records either edge.
- Clearing an enable does not clear pending stat.

## Timing

- Reset, asynchronous while reset==0:
  - rd_data=0, rdy_=1, gpio_out=0, io_out=0, io_dir=0 (all Hi-Z).
  - IRQ_RISE=0, IRQ_FALL=0, stat=0, irq=0.
  - s1/s2/prev=0.
- Reset asserted mid-access aborts it; no partial register update.
- rdy_ goes low on the edge after an access is sampled, for one cycle per sampled cycle. It is 1 otherwise.
- rd_data is valid in the same cycle rdy_ is low. It is 0 in every non-read cycle.
- Writes take effect on the sampling edge, so gpio_out/gpio_io change 1 cycle after the access.
- Input latency: a pin change meeting setup before edge N appears in s2 after edge N+1. IN_DATA/IO_DATA reads reflect it from then on. stat and irq set at edge N+2.
- Simultaneous edge event and W1C of the same bit: set wins, bit stays 1.
- After reset, edges cannot be recorded until software enables them, so reset-release transients do not raise stat.
- OUT_SET/OUT_CLR wr_data bits ≥ OUT_CH are ignored. A write of 0 is a no-op that is still acknowledged.

## Structure

- Shared header gpio.h holds:
  - register address constants (GPIO_ADDR_IN_DATA … GPIO_ADDR_IRQ_STAT);
  - GPIO_DIR_IN=0, GPIO_DIR_OUT=1;
  - READ/WRITE and enable-polarity constants from the global headers.
- One sub-module, gpio_sync_edge (parameter W): two-flop synchronizer plus prev flop. Outputs sync, rise and fall; uses the same clk/reset.
- The top level holds the register file, bus FSM-less single-cycle decode, tristate drivers and irq flop.

## Test plan

- Reset state: assert reset low mid-write to OUT_DATA (wr_data=0x3FFFF) -> gpio_out=0, gpio_io all Z, irq=0, rdy_=1, rd_data=0. A read of addr 3 after release returns 0.
- Set/clear: write OUT_DATA=0x00F0, then OUT_SET=0x0003, then OUT_CLR=0x0030. Expect gpio_out 0x00F0 → 0x00F3 → 0x00C3. Each access gets rdy_ low the next cycle and rd_data=0.
- Bidirectional readback: write IO_DIR=0x00FF and IO_DATA=0xA5A5, with the bench driving gpio_io[15:8]=0x3C. Two cycles later, a read of addr 2 returns 0x00003CA5.
- Rising edge irq: write IRQ_RISE=0x1 and toggle gpio_in[0] 0→1 at edge N. Expect stat=0x1 and irq=1 at edge N+2. A falling edge with IRQ_FALL=0 changes nothing. Write IRQ_STAT=0x1 → irq=0 next cycle.
- Both edges and collision: set IRQ_RISE=IRQ_FALL=bit 4 (gpio_io[0]). A pulse yields stat bit 4. Time a W1C of bit 4 to coincide with a new edge: bit stays 1 and irq stays 1.
- Unmapped/read-only: writes to addr 0, 10 and 15 with 0xFFFFFFFF change no register. Reads of addr 4, 5 and 12 return 0, and rdy_ still asserts.
